xbox_xlr_matmul_nxn: RTL and testbench

//  Parametrised NxN matrix-multiply accelerator (C = A*B), successor to the fixed 2x2 XBOX accelerator.

---
 rtl/xbox_xlr_matmul_nxn.sv | 167 ++++++++++++++++
 tb/tb_xbox_xlr_matmul_nxn.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbox_xlr_matmul_nxn.sv
// NxN matrix-multiply accelerator: C = A*B, A/B rows from MEM0, C rows to MEM1.
// Ports: clk, rst_n, xlr_mem_* (per-memory line bus), host_regs* (CSR bank).
module xbox_xlr_matmul_nxn #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 5,
  parameter int MAX_DIM            = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
  output logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_wdata,
  output logic [NUM_MEMS-1:0][31:0]                    xlr_mem_be,
  output logic [NUM_MEMS-1:0]                          xlr_mem_rd,
  output logic [NUM_MEMS-1:0]                          xlr_mem_wr,
  input  logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_rdata,
  input  logic [31:0][31:0]                            host_regs,
  input  logic [31:0]                                  host_regs_valid_pulse,
  output logic [31:0][31:0]                            host_regs_data_out,
  output logic [31:0]                                  host_regs_valid_out
);

  localparam int L = LOG2_LINES_PER_MEM;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TAIL, S_WRITE, S_FIN
  } state_t;

  state_t      state;
  logic [4:0]  r;
  logic [3:0]  n;
  logic [L-1:0] a_base, b_base, c_base;
  logic        done, err;
  logic        done_nxt, err_nxt;
  logic [31:0] a_buf [MAX_DIM][MAX_DIM];
  logic [31:0] b_buf [MAX_DIM][MAX_DIM];
  logic [31:0] a_row [MAX_DIM];
  logic [31:0] c_row [MAX_DIM];

  logic [31:0] cfg;
  logic        start, cfg_bad;
  logic [4:0]  nx, n2, cap;
  logic        unused;

  assign cfg     = host_regs[4];
  assign start   = (host_regs[0] == 32'd1) && host_regs_valid_pulse[0];
  assign cfg_bad = (cfg[3:0] == 4'd0) || (int'(cfg[3:0]) > MAX_DIM);
  assign nx      = {1'b0, n};
  assign n2      = {n, 1'b0};
  // Row index of the line whose read data is on rdata this cycle.
  assign cap     = r - 5'd1;
  assign unused  = ^{host_regs, host_regs_valid_pulse, xlr_mem_rdata};

  always_comb begin
    done_nxt = done;
    err_nxt  = err;
    if (state == S_IDLE && start) begin
      done_nxt = cfg_bad;
      err_nxt  = cfg_bad;
    end
    if (state == S_FIN) done_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      r      <= '0;
      n      <= '0;
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
      end
    end else begin
      done <= done_nxt;
      err  <= err_nxt;
      if ((state == S_LOAD && r != 5'd0) || state == S_TAIL) begin
        for (int i = 0; i < MAX_DIM; i++) begin
          for (int j = 0; j < MAX_DIM; j++) begin
            if (cap == 5'(i) && 5'(i) < nx)
              a_buf[i][j] <= xlr_mem_rdata[0][j];
            if (cap == nx + 5'(i))
              b_buf[i][j] <= xlr_mem_rdata[0][j];
          end
        end
      end
      unique case (1'b1)
        state == S_IDLE: begin
          if (start && !cfg_bad) begin
            n      <= cfg[3:0];
            a_base <= cfg[8 +: L];
            b_base <= cfg[16 +: L];
            c_base <= cfg[24 +: L];
            r      <= '0;
            state  <= S_LOAD;
          end
        end
        state == S_LOAD: begin
          r <= r + 5'd1;
          if (r == n2 - 5'd1) state <= S_TAIL;
        end
        state == S_TAIL: begin
          r     <= '0;
          state <= S_WRITE;
        end
        state == S_WRITE: begin
          if (r == nx - 5'd1) state <= S_FIN;
          else r <= r + 5'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_regs_data_out  <= '0;
      host_regs_valid_out <= 32'h24;
    end else begin
      host_regs_data_out[2] <= {31'b0, state != S_IDLE};
      host_regs_data_out[3] <= {31'b0, done_nxt};
      host_regs_data_out[5] <= {31'b0, err_nxt};
      host_regs_valid_out   <= {26'b0, 1'b1, 1'b0, done_nxt, 1'b1, 2'b0};
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_DIM; k++) a_row[k] = '0;
    for (int i = 0; i < MAX_DIM; i++)
      if (r == 5'(i)) a_row = a_buf[i];
    for (int j = 0; j < MAX_DIM; j++) begin
      c_row[j] = '0;
      for (int k = 0; k < MAX_DIM; k++)
        if (5'(k) < nx)
          c_row[j] = c_row[j] + a_row[k] * b_buf[k][j];
    end
  end

  always_comb begin
    xlr_mem_addr  = '0;
    xlr_mem_wdata = '0;
    xlr_mem_be    = '0;
    xlr_mem_rd    = '0;
    xlr_mem_wr    = '0;
    if (state == S_LOAD) begin
      xlr_mem_rd[0] = 1'b1;
      xlr_mem_addr[0] = (r < nx) ? a_base + L'(r)
                                 : b_base + L'(r - nx);
    end
    if (state == S_WRITE) begin
      xlr_mem_wr[1]   = 1'b1;
      xlr_mem_addr[1] = c_base + L'(r);
      for (int j = 0; j < MAX_DIM; j++) begin
        if (5'(j) < nx) begin
          xlr_mem_wdata[1][j]    = c_row[j];
          xlr_mem_be[1][4*j +: 4] = 4'hF;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbox_xlr_matmul_nxn.sv
// Self-checking bench for xbox_xlr_matmul_nxn.
// Drives CSRs, models MEM0, scoreboards MEM1 writes.
module tb_xbox_xlr_matmul_nxn;

  localparam int NM = 2;
  localparam int L  = 5;
  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM-1:0][L-1:0]     xlr_mem_addr;
  logic [NM-1:0][7:0][31:0] xlr_mem_wdata;
  logic [NM-1:0][31:0]      xlr_mem_be;
  logic [NM-1:0]            xlr_mem_rd;
  logic [NM-1:0]            xlr_mem_wr;
  logic [NM-1:0][7:0][31:0] xlr_mem_rdata;
  logic [31:0][31:0]        host_regs;
  logic [31:0]              host_regs_valid_pulse;
  logic [31:0][31:0]        host_regs_data_out;
  logic [31:0]              host_regs_valid_out;

  xbox_xlr_matmul_nxn #(
    .NUM_MEMS(NM), .LOG2_LINES_PER_MEM(L), .MAX_DIM(MD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .xlr_mem_addr(xlr_mem_addr),
    .xlr_mem_wdata(xlr_mem_wdata),
    .xlr_mem_be(xlr_mem_be),
    .xlr_mem_rd(xlr_mem_rd),
    .xlr_mem_wr(xlr_mem_wr),
    .xlr_mem_rdata(xlr_mem_rdata),
    .host_regs(host_regs),
    .host_regs_valid_pulse(host_regs_valid_pulse),
    .host_regs_data_out(host_regs_data_out),
    .host_regs_valid_out(host_regs_valid_out)
  );

  typedef struct {
    logic [4:0]       addr;
    logic [7:0][31:0] data;
    logic [31:0]      be;
  } exp_t;

  exp_t sb[$];

  logic [31:0]      mem0 [32][8];
  logic [7:0][31:0] rdq;
  logic [31:0]      ga [8][8];
  logic [31:0]      gb [8][8];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int bad_cnt = 0;
  int busy_cnt = 0;
  int last_wr_cyc = 0;
  int start_cyc = 0;

  assign xlr_mem_rdata = {256'b0, rdq};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (xlr_mem_rd[0])
      for (int j = 0; j < 8; j++) rdq[j] <= mem0[xlr_mem_addr[0]][j];
  end

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (xlr_mem_rd[0]) rd_cnt++;
    if (xlr_mem_rd[1] || xlr_mem_wr[0]) bad_cnt++;
    if (host_regs_data_out[2][0]) busy_cnt++;
    if (xlr_mem_wr[1]) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("wr_expected", 512'(sb.size() != 0), 512'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 512'(xlr_mem_addr[1]), 512'(e.addr));
        check("wr_data", 512'(xlr_mem_wdata[1]), 512'(e.data));
        check("wr_be", 512'(xlr_mem_be[1]), 512'(e.be));
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int n, input int a, input int b,
                         input int c);
    host_regs[4] = {8'(c), 8'(b), 8'(a), 4'b0, 4'(n)};
    host_regs_valid_pulse[4] = 1'b1;
    tick();
    host_regs_valid_pulse[4] = 1'b0;
  endtask

  task automatic pulse_start();
    host_regs[0] = 32'd1;
    host_regs_valid_pulse[0] = 1'b1;
    start_cyc = cyc;
    tick();
    host_regs_valid_pulse[0] = 1'b0;
  endtask

  // Fill MEM0 (unused words hold junk) and queue the expected C rows.
  task automatic prep(input int n, input int a, input int b, input int c);
    exp_t e;
    logic [31:0] s;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        mem0[(a + i) % 32][j] = (j < n) ? ga[i][j] : 32'hBAD0_0000 + j;
        mem0[(b + i) % 32][j] = (j < n) ? gb[i][j] : 32'hBEE0_0000 + j;
      end
    end
    for (int i = 0; i < n; i++) begin
      e.addr = 5'((c + i) % 32);
      e.be = '0;
      for (int j = 0; j < 8; j++) begin
        s = '0;
        if (j < n) begin
          for (int k = 0; k < n; k++) s = s + ga[i][k] * gb[k][j];
          e.be = e.be | (32'hF << (4 * j));
        end
        e.data[j] = s;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!host_regs_data_out[3][0] && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_done_in_time"}, 512'(k < 200), 512'(1));
    tick();
    check({tag, "_busy_low"}, 512'(host_regs_data_out[2]), 512'(0));
    check({tag, "_err_low"}, 512'(host_regs_data_out[5]), 512'(0));
    check({tag, "_sb_drained"}, 512'(sb.size()), 512'(0));
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_addr"}, 512'(xlr_mem_addr), 512'(0));
    check({tag, "_wdata"}, 512'(xlr_mem_wdata), 512'(0));
    check({tag, "_be"}, 512'(xlr_mem_be), 512'(0));
    check({tag, "_strobes"}, 512'({xlr_mem_rd, xlr_mem_wr}), 512'(0));
    check({tag, "_csr"}, 512'(|host_regs_data_out), 512'(0));
  endtask

  initial begin
    int rd0;
    int wr0;
    int k;
    rst_n = 1'b0;
    host_regs = '0;
    host_regs_valid_pulse = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 8; j++) mem0[i][j] = '0;
    tick(2);
    chk_idle_outputs("reset");
    check("reset_valid", 512'(host_regs_valid_out), 512'(32'h24));
    rst_n = 1'b1;
    tick(2);

    // 2x2 basic product
    ga[0][0] = 1; ga[0][1] = 2; ga[1][0] = 3; ga[1][1] = 4;
    gb[0][0] = 5; gb[0][1] = 6; gb[1][0] = 7; gb[1][1] = 8;
    prep(2, 0, 2, 0);
    check("t1_row0_c00", 512'(sb[0].data[0]), 512'(19));
    check("t1_row1_c11", 512'(sb[1].data[1]), 512'(50));
    set_cfg(2, 0, 2, 0);
    pulse_start();
    wait_done("t1");
    check("t1_latency", 512'(last_wr_cyc - start_cyc), 512'(7));
    check("t1_done", 512'(host_regs_data_out[3]), 512'(1));
    check("t1_valid", 512'(host_regs_valid_out), 512'(32'h2C));

    // 4x4 identity * 1..16
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ga[i][j] = (i == j) ? 32'd1 : 32'd0;
        gb[i][j] = 32'(4 * i + j + 1);
      end
    prep(4, 4, 8, 12);
    set_cfg(4, 4, 8, 12);
    busy_cnt = 0;
    pulse_start();
    wait_done("t2");
    check("t2_busy_cycles", 512'(busy_cnt), 512'(14));
    check("t2_latency", 512'(last_wr_cyc - start_cyc), 512'(13));

    // signed wrap
    ga[0][0] = 32'hFFFF_FFFF; ga[0][1] = 0;
    ga[1][0] = 0; ga[1][1] = 32'hFFFF_FFFF;
    gb[0][0] = 32'h7FFF_FFFF; gb[0][1] = 2;
    gb[1][0] = 3; gb[1][1] = 32'hFFFF_FFFC;
    prep(2, 16, 18, 20);
    check("t3_c00", 512'(sb[0].data[0]), 512'(32'h8000_0001));
    check("t3_c11", 512'(sb[1].data[1]), 512'(4));
    set_cfg(2, 16, 18, 20);
    pulse_start();
    wait_done("t3");

    // N=0 rejected
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    set_cfg(0, 0, 0, 0);
    pulse_start();
    tick(3);
    check("t4a_err", 512'(host_regs_data_out[5]), 512'(1));
    check("t4a_done", 512'(host_regs_data_out[3]), 512'(1));
    check("t4a_busy", 512'(host_regs_data_out[2]), 512'(0));
    check("t4a_no_rd", 512'(rd_cnt - rd0), 512'(0));
    check("t4a_no_wr", 512'(wr_cnt - wr0), 512'(0));

    // N=3, C wraps 31->0->1, start/CFG during LOAD ignored
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ga[i][j] = $urandom;
        gb[i][j] = $urandom;
      end
    prep(3, 24, 27, 31);
    check("t5_wrap_addr", 512'(sb[1].addr), 512'(0));
    set_cfg(3, 24, 27, 31);
    wr0 = wr_cnt;
    pulse_start();
    check("t5_err_cleared", 512'(host_regs_data_out[5]), 512'(0));
    tick(2);
    host_regs[4] = {8'd5, 8'd0, 8'd0, 8'd2};
    host_regs_valid_pulse[4] = 1'b1;
    host_regs_valid_pulse[0] = 1'b1;
    tick();
    host_regs_valid_pulse = '0;
    wait_done("t5");
    check("t5_latency", 512'(last_wr_cyc - start_cyc), 512'(10));
    tick(10);
    check("t5_wr_count", 512'(wr_cnt - wr0), 512'(3));

    // N=MAX_DIM+1 rejected
    rd0 = rd_cnt;
    set_cfg(MD + 1, 0, 0, 0);
    pulse_start();
    tick(3);
    check("t4b_err", 512'(host_regs_data_out[5]), 512'(1));
    check("t4b_busy", 512'(host_regs_data_out[2]), 512'(0));
    check("t4b_no_rd", 512'(rd_cnt - rd0), 512'(0));

    // reset during WRITE, then rerun
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ga[i][j] = 32'(i + 2 * j + 1);
        gb[i][j] = 32'(3 * i + j + 7);
      end
    prep(3, 0, 3, 8);
    set_cfg(3, 0, 3, 8);
    pulse_start();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!xlr_mem_wr[1] && k < 100);
    check("t6_first_wr_seen", 512'(k < 100), 512'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_in_reset");
    sb.delete();
    wr0 = wr_cnt;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("t6_no_more_wr", 512'(wr_cnt - wr0), 512'(0));
    check("t6_csr_cleared", 512'(host_regs_data_out[3]), 512'(0));
    prep(3, 0, 3, 8);
    pulse_start();
    wait_done("t6");
    check("t6_latency", 512'(last_wr_cyc - start_cyc), 512'(10));

    check("illegal_strobes", 512'(bad_cnt), 512'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
